uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

Receive-side program loader: deserialises an 8N1 UART byte stream on `RXD`, assembles each four-byte group into one 32-bit word, and writes it to sequential word addresses of the boot memory. It is the counterpart of the `UARTTX` sender the simulation top drives. It asserts `DONE` once the full image (2**`ADDR_WIDTH` words) has been written, which releases the CPU from load.

## Interface

Parameters:

- `SERIAL_WCNT`, default 868: clock cycles per UART bit. Minimum 2. Must match the sender.
- `ADDR_WIDTH`, default 17: word-address width. The image is 2**`ADDR_WIDTH` words.

Ports (name, direction, width, meaning):

- `CLK` in 1: clock.
- `RST_X` in 1: reset, asynchronous, active-low.
- `RXD` in 1: serial input. Idle high. Asynchronous to `CLK`.
- `WE` out 1: one-cycle write strobe.
- `WADDR` out `ADDR_WIDTH`: word address. Valid while `WE` is high.
- `WDATA` out 32: assembled word. Valid while `WE` is high.
- `DONE` out 1: image complete. Sticky until reset.
- `ERR` out 1: sticky framing error seen.
- `CHECKSUM` out 32: present only with `PLOADER_CHECKSUM_EN`.

## Operation

- `RXD` passes through a 2-flop synchroniser. All decisions use the synchronised value `rxs`.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE: stay while `rxs` is 1. A 1→0 transition moves to START and loads the bit counter with `SERIAL_WCNT/2 - 1`.
  - START: on counter expiry, sample `rxs`. If 1 (false start) → IDLE. If 0 → DATA, with the counter reloaded to `SERIAL_WCNT-1` and the bit index at 0.
  - DATA: on each expiry, shift `rxs` into the byte LSB-first and reload the counter. After bit 7 → STOP.
  - STOP: on expiry, sample `rxs`, then → IDLE.
    - If `rxs`=1: the byte is valid.
    - If `rxs`=0: the byte is discarded, `ERR` is set, and the assembler does not advance.
- Word assembler: a 2-bit byte index and a 32-bit shift register. The first byte received lands in `WDATA[31:24]` and the fourth in `WDATA[7:0]` (big-endian order, matching the sender).
  - On the fourth valid byte: `WE`=1 for one cycle with the current `WADDR`.
  - `WADDR` increments the cycle after `WE`.
- Completion:
  - On the write where `WADDR` = 2**`ADDR_WIDTH`-1, `DONE` sets the next cycle.
  - `WADDR` wraps to 0 and is not used again.
- While `DONE`=1: the receiver keeps running, but valid bytes are ignored. No further `WE`, and `WADDR`, `WDATA` and `CHECKSUM` stay frozen.
- A framing error does not reset the byte index. Only the corrupt byte is dropped.

## Timing

- All outputs are 0 on reset. This includes `WADDR`=0, `WDATA`=0, `DONE`=0, `ERR`=0 and `CHECKSUM`=0. The FSM resets to IDLE.
- Reset assertion at any point, including mid-byte or mid-word, aborts the transfer. There is no partial write.
- Latency from the `RXD` falling edge of the start bit to the stop-bit sample: 2 (synchroniser) + `SERIAL_WCNT/2` + 9·`SERIAL_WCNT` cycles.
- `WE` follows the stop-bit sample of the fourth byte by exactly 1 cycle.
- `DONE` rises 1 cycle after the final `WE`.
- Back-to-back frames are accepted: the stop bit is sampled mid-bit, so IDLE is re-entered in time to catch the next start edge.

## Configuration

- `PLOADER_CHECKSUM_EN` defined:
  - The `CHECKSUM` port exists.
  - On every `WE`, `CHECKSUM` ← `CHECKSUM` + `WDATA` (mod 2**32).
  - The register updates in the same cycle `WADDR` increments.
- `PLOADER_CHECKSUM_EN` undefined:
  - No `CHECKSUM` port and no adder.
  - All other behaviour is identical.

## Structure

- Shared package holds:
  - the receiver state encoding (IDLE=0, START=1, DATA=2, STOP=3);
  - the word width constant (32).
- One sub-module, `UARTRX`, contains the synchroniser, the FSM, and the bit and counter logic.
  - Ports: `CLK`, `RST_X`, `RXD`, `DATA`[8], `VALID` (1-cycle pulse), `FERR` (1-cycle pulse).
  - Parameter: `SERIAL_WCNT`.
- The top of this block holds the word assembler, address counter, `DONE`/`ERR` and the optional checksum.

## Test plan

Bench uses `SERIAL_WCNT`=2 and `ADDR_WIDTH`=2 unless stated, and is driven by `UARTTX`.

1. Send bytes 0x12, 0x34, 0x56, 0x78 → exactly one `WE` with `WADDR`=0 and `WDATA`=0x12345678. `DONE` stays 0.
2. Send 16 bytes 0x00–0x0F → `WE` at addresses 0, 1, 2, 3 with data 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F. `DONE`=1 one cycle after the last `WE`. Then send 4 more bytes → no `WE`, and `WADDR` stays 0.
3. Force the stop bit of byte 2 low (byte 0xAA) and resend it correctly → `ERR`=1. The word written is {b1, b2-correct, b3, b4}. `WADDR` is unaffected by the bad byte.
4. Apply a 1-cycle low glitch on idle `RXD` → false start detected, no `VALID`, no `WE`.
5. Assert `RST_X` low after 2 bytes, release, then send 0xDEADBEEF → `WE` with `WADDR`=0 and `WDATA`=0xDEADBEEF.
6. With `PLOADER_CHECKSUM_EN`, send words 0xFFFFFFFF, 0x00000002, 0x10, 0x20 → `CHECKSUM`=0x00000031 once `DONE` is set.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: receiver state encoding
// and the boot-memory word width.
package uart_prog_loader_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_prog_loader_uartrx.sv
// UARTRX: 8N1 byte receiver. Synchronises RXD, samples each bit mid-period and
// pulses VALID (good stop bit) or FERR (low stop bit) in the stop-sample cycle.
module UARTRX
  import uart_prog_loader_pkg::*;
#(
  parameter int SERIAL_WCNT = 868
) (
  input  logic       CLK,
  input  logic       RST_X,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FERR
);

  localparam int CW = $clog2(SERIAL_WCNT + 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(SERIAL_WCNT / 2 - 1);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(SERIAL_WCNT - 1);

  // [0] metastability flop, [1] rxs, [2] previous rxs for edge detect
  logic [2:0] sync_pipe;
  logic       rxs, rxs_d;

  rx_state_e   state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]  bit_q, bit_n;
  logic [7:0]  sh_q, sh_n;
  logic        expire;

  assign rxs    = sync_pipe[1];
  assign rxs_d  = sync_pipe[2];
  assign expire = (cnt_q == '0);
  assign DATA   = sh_q;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      sync_pipe <= 3'b111;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], RXD};
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      bit_q     <= bit_n;
      sh_q      <= sh_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = expire ? cnt_q : cnt_q - 1'b1;
    bit_n   = bit_q;
    sh_n    = sh_q;
    VALID   = 1'b0;
    FERR    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        // edge, not level: a low line left by a framing error must not retrigger
        if (!rxs && rxs_d) begin
          state_n = RX_START;
          cnt_n   = HALF_RELOAD;
        end
      end
      RX_START: begin
        if (expire) begin
          if (rxs) begin
            state_n = RX_IDLE;
          end else begin
            state_n = RX_DATA;
            cnt_n   = FULL_RELOAD;
            bit_n   = '0;
          end
        end
      end
      RX_DATA: begin
        if (expire) begin
          sh_n  = {rxs, sh_q[7:1]};
          cnt_n = FULL_RELOAD;
          bit_n = bit_q + 3'd1;
          if (bit_q == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (expire) begin
          state_n = RX_IDLE;
          VALID   = rxs;
          FERR    = !rxs;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot-image loader: packs received bytes big-endian into words and writes
// them to sequential addresses. Optional running sum enabled by PLOADER_CHECKSUM_EN.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int SERIAL_WCNT = 868,
  parameter int ADDR_WIDTH  = 17
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic                  RXD,
  output logic                  WE,
  output logic [ADDR_WIDTH-1:0] WADDR,
  output logic [WORD_W-1:0]     WDATA,
  output logic                  DONE,
`ifdef PLOADER_CHECKSUM_EN
  output logic                  ERR,
  output logic [WORD_W-1:0]     CHECKSUM
`else
  output logic                  ERR
`endif
);

  logic [7:0]  rx_data;
  logic        rx_valid, rx_ferr;
  logic [1:0]  byte_idx;
  logic [23:0] shreg;
  logic        accept;

  UARTRX #(.SERIAL_WCNT(SERIAL_WCNT)) u_rx (
    .CLK  (CLK),
    .RST_X(RST_X),
    .RXD  (RXD),
    .DATA (rx_data),
    .VALID(rx_valid),
    .FERR (rx_ferr)
  );

  // once the image is complete, bytes keep arriving but change nothing
  assign accept = rx_valid && !DONE;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      byte_idx <= '0;
      shreg    <= '0;
      WE       <= 1'b0;
      WADDR    <= '0;
      WDATA    <= '0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      WE <= 1'b0;
      if (rx_ferr) ERR <= 1'b1;
      if (accept) begin
        shreg    <= {shreg[15:0], rx_data};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          WE    <= 1'b1;
          WDATA <= {shreg, rx_data};
        end
      end
      if (WE) begin
        WADDR <= WADDR + 1'b1;
        if (&WADDR) DONE <= 1'b1;
      end
    end
  end

`ifdef PLOADER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X)  CHECKSUM <= '0;
    else if (WE) CHECKSUM <= CHECKSUM + WDATA;
  end
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with SERIAL_WCNT=2, ADDR_WIDTH=2; a
// task-level UART sender drives RXD and a monitor logs every write strobe.
module tb_uart_prog_loader;

  localparam int W  = 2;
  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          RST_X = 1'b0;
  logic          RXD = 1'b1;
  logic          WE;
  logic [AW-1:0] WADDR;
  logic [31:0]   WDATA;
  logic          DONE;
  logic          ERR;
`ifdef PLOADER_CHECKSUM_EN
  logic [31:0]   CHECKSUM;
`endif

  uart_prog_loader #(.SERIAL_WCNT(W), .ADDR_WIDTH(AW)) dut (
    .CLK  (CLK),
    .RST_X(RST_X),
    .RXD  (RXD),
    .WE   (WE),
    .WADDR(WADDR),
    .WDATA(WDATA),
    .DONE (DONE),
`ifdef PLOADER_CHECKSUM_EN
    .ERR     (ERR),
    .CHECKSUM(CHECKSUM)
`else
    .ERR  (ERR)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, we_n = 0, vcnt = 0, last_we_cyc = -1, done_cyc = -1;
  logic [AW-1:0] cap_addr[$];
  logic [31:0]   cap_data[$];

  always @(negedge CLK) begin
    cyc++;
    if (dut.u_rx.VALID) vcnt++;
    if (WE) begin
      we_n++;
      last_we_cyc = cyc;
      cap_addr.push_back(WADDR);
      cap_data.push_back(WDATA);
    end
    if (DONE && done_cyc < 0) done_cyc = cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] qdata(input int k);
    return (cap_data.size() > k) ? cap_data[k] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] qaddr(input int k);
    return (cap_addr.size() > k) ? 32'(cap_addr[k]) : 32'hxxxxxxxx;
  endfunction

  task automatic drive_bit(input logic v);
    RXD = v;
    repeat (W) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RXD = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], 1'b1);
  endtask

  task automatic clear_log();
    we_n = 0; vcnt = 0; last_we_cyc = -1; done_cyc = -1;
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic do_reset();
    RST_X = 1'b0;
    idle(3);
    RST_X = 1'b1;
    clear_log();
    idle(2);
  endtask

  typedef struct {
    logic [31:0]   word;
    logic [AW-1:0] addr;
    logic          done;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int v0, w0;
    tbl[0] = '{32'h00010203, 2'd0, 1'b0};
    tbl[1] = '{32'h04050607, 2'd1, 1'b0};
    tbl[2] = '{32'h08090A0B, 2'd2, 1'b0};
    tbl[3] = '{32'h0C0D0E0F, 2'd3, 1'b1};

    // reset values
    idle(3);
    chk("rst_we", 32'(WE), 32'd0);
    chk("rst_waddr", 32'(WADDR), 32'd0);
    chk("rst_wdata", WDATA, 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
`ifdef PLOADER_CHECKSUM_EN
    chk("rst_checksum", CHECKSUM, 32'd0);
`endif
    RST_X = 1'b1;
    clear_log();
    idle(4);

    // single word, back-to-back bytes
    send_word(32'h12345678);
    idle(8);
    chk("t1_we_count", 32'(we_n), 32'd1);
    chk("t1_waddr", qaddr(0), 32'd0);
    chk("t1_wdata", qdata(0), 32'h12345678);
    chk("t1_done", 32'(DONE), 32'd0);

    // full image from the vector table
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_word(tbl[i].word);
      idle(8);
      chk($sformatf("t2_we_count_%0d", i), 32'(we_n), 32'(i + 1));
      chk($sformatf("t2_waddr_%0d", i), qaddr(i), 32'(tbl[i].addr));
      chk($sformatf("t2_wdata_%0d", i), qdata(i), tbl[i].word);
      chk($sformatf("t2_done_%0d", i), 32'(DONE), 32'(tbl[i].done));
    end
    chk("t2_done_latency", 32'(done_cyc - last_we_cyc), 32'd1);
    send_word(32'hA5A5A5A5);
    idle(8);
    chk("t2_post_done_we", 32'(we_n), 32'd4);
    chk("t2_post_done_waddr", 32'(WADDR), 32'd0);
    chk("t2_post_done_wdata", WDATA, 32'h0C0D0E0F);
    chk("t2_post_done_done", 32'(DONE), 32'd1);

    // framing error on byte 2, then resent correctly
    do_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'hAA, 1'b0);
    idle(4);
    chk("t3_err_set", 32'(ERR), 32'd1);
    chk("t3_no_we_yet", 32'(we_n), 32'd0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    idle(8);
    chk("t3_we_count", 32'(we_n), 32'd1);
    chk("t3_waddr", qaddr(0), 32'd0);
    chk("t3_wdata", qdata(0), 32'h11AA3344);
    chk("t3_waddr_after", 32'(WADDR), 32'd1);

    // one-cycle low glitch on idle line
    v0 = vcnt; w0 = we_n;
    RXD = 1'b0;
    @(posedge CLK); #1;
    idle(24);
    chk("t4_no_valid", 32'(vcnt - v0), 32'd0);
    chk("t4_no_we", 32'(we_n - w0), 32'd0);

    // reset mid-word aborts without a partial write
    do_reset();
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    do_reset();
    send_word(32'hDEADBEEF);
    idle(8);
    chk("t5_we_count", 32'(we_n), 32'd1);
    chk("t5_waddr", qaddr(0), 32'd0);
    chk("t5_wdata", qdata(0), 32'hDEADBEEF);

`ifdef PLOADER_CHECKSUM_EN
    do_reset();
    send_word(32'hFFFFFFFF); idle(8);
    send_word(32'h00000002); idle(8);
    send_word(32'h00000010); idle(8);
    send_word(32'h00000020); idle(8);
    chk("t6_done", 32'(DONE), 32'd1);
    chk("t6_checksum", CHECKSUM, 32'h00000031);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
